// File: rtl/canvas_sequencer.sv
// canvas_sequencer: owns the 32x32 one-bit drawing canvas and schedules access to it
// Latency: paint is acked and committed on the same edge; streamed rows go out at one per accepted handshake
// Backpressure: rows hold while iRowReady is low; paint stalls with no ack outside IDLE
//
// Ports:
//   iBusClk, iRst           clock, synchronous active-high reset
//   iPaint*/oPaintAck       pixel write request from the mouse path; oPaintAck pulses on commit
//   iClear                  whole-canvas clear sweep, one row per cycle; cancels a stream (oAbort)
//   iStart/oRow*/iRowReady  row-by-row frame stream to the DNN loader; oFrameDone ends it
//   oBusy                   high whenever the sequencer is not IDLE
//   iDispRow/oDispData      combinational row read for the VGA renderer
//   oInkCount               running count of set pixels
// Optional feature macro: AUTO_CLEAR_EN -- a completed frame is followed directly by a clear sweep.
module canvas_sequencer #(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  parameter int AW   = 5,
  parameter int CW   = 11
) (
  input  logic            iBusClk,
  input  logic            iRst,
  input  logic            iPaintReq,
  input  logic [AW-1:0]   iPaintX,
  input  logic [AW-1:0]   iPaintY,
  input  logic            iPaintVal,
  output logic            oPaintAck,
  input  logic            iClear,
  input  logic            iStart,
  output logic            oRowValid,
  output logic [AW-1:0]   oRowIdx,
  output logic [COLS-1:0] oRowData,
  input  logic            iRowReady,
  output logic            oFrameDone,
  output logic            oAbort,
  output logic            oBusy,
  input  logic [AW-1:0]   iDispRow,
  output logic [COLS-1:0] oDispData,
  output logic [CW-1:0]   oInkCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [COLS-1:0] r_canvas [ROWS];
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_ink;
  logic            r_abort;

  logic            w_paint_ack;
  logic            w_ptr_clr;
  logic            w_abort;
  logic            w_last_row;
  logic            w_old_pix;

  assign w_last_row = (r_ptr == AW'(ROWS - 1));
  assign w_old_pix  = r_canvas[iPaintY][iPaintX];

  // State register
  always_ff @(posedge iBusClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and per-cycle controls; IDLE priority is clear > start > paint
  always_comb begin
    w_state_nxt = r_state;
    w_paint_ack = 1'b0;
    w_ptr_clr   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iClear) begin
          w_state_nxt = S_CLEAR;
          w_ptr_clr   = 1'b1;
        end else if (iStart) begin
          w_state_nxt = S_STREAM;
          w_ptr_clr   = 1'b1;
        end else if (iPaintReq) begin
          w_paint_ack = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_last_row) w_state_nxt = S_IDLE;
      end
      S_STREAM: begin
        // A clear cancels the frame even if the current row handshakes this cycle
        if (iClear) begin
          w_state_nxt = S_CLEAR;
          w_ptr_clr   = 1'b1;
          w_abort     = 1'b1;
        end else if (iRowReady && w_last_row) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
`ifdef AUTO_CLEAR_EN
        w_state_nxt = S_CLEAR;
        w_ptr_clr   = 1'b1;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row pointer shared by the clear sweep and the stream
  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      r_ptr <= '0;
    end else if (w_ptr_clr) begin
      r_ptr <= '0;
    end else if ((r_state == S_CLEAR) || ((r_state == S_STREAM) && iRowReady)) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  // Canvas storage: clear sweep zeroes one row per cycle, paint writes one pixel
  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      for (int i = 0; i < ROWS; i++) r_canvas[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_canvas[r_ptr] <= '0;
    end else if (w_paint_ack) begin
      r_canvas[iPaintY][iPaintX] <= iPaintVal;
    end
  end

  // Ink count tracks only real pixel flips; it drops to zero as a clear sweep begins,
  // so it already reflects the final blank canvas during the sweep
  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      r_ink <= '0;
    end else if (w_state_nxt == S_CLEAR) begin
      r_ink <= '0;
    end else if (w_paint_ack && iPaintVal && !w_old_pix) begin
      r_ink <= r_ink + CW'(1);
    end else if (w_paint_ack && !iPaintVal && w_old_pix) begin
      r_ink <= r_ink - CW'(1);
    end
  end

  // Abort pulse appears in the first CLEAR cycle after a cancelled stream
  always_ff @(posedge iBusClk) begin
    if (iRst) r_abort <= 1'b0;
    else      r_abort <= w_abort;
  end

  assign oPaintAck  = w_paint_ack;
  assign oRowValid  = (r_state == S_STREAM);
  assign oRowIdx    = (r_state == S_STREAM) ? r_ptr : '0;
  assign oRowData   = r_canvas[r_ptr];
  assign oFrameDone = (r_state == S_DONE);
  assign oAbort     = r_abort;
  assign oBusy      = (r_state != S_IDLE);
  assign oDispData  = r_canvas[iDispRow];
  assign oInkCount  = r_ink;

endmodule

// File: tb/tb_canvas_sequencer.sv
// tb_canvas_sequencer: directed bench for canvas_sequencer with hand-computed expectations
// Inputs are driven 1 ns after the rising edge; outputs are sampled before the next edge
// Honours AUTO_CLEAR_EN when the build defines it
module tb_canvas_sequencer;
  localparam int AW   = 5;
  localparam int COLS = 32;
  localparam int CW   = 11;

  logic            iBusClk = 1'b0;
  logic            iRst = 1'b1;
  logic            iPaintReq = 1'b0;
  logic [AW-1:0]   iPaintX = '0;
  logic [AW-1:0]   iPaintY = '0;
  logic            iPaintVal = 1'b0;
  logic            oPaintAck;
  logic            iClear = 1'b0;
  logic            iStart = 1'b0;
  logic            oRowValid;
  logic [AW-1:0]   oRowIdx;
  logic [COLS-1:0] oRowData;
  logic            iRowReady = 1'b0;
  logic            oFrameDone;
  logic            oAbort;
  logic            oBusy;
  logic [AW-1:0]   iDispRow = '0;
  logic [COLS-1:0] oDispData;
  logic [CW-1:0]   oInkCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 iBusClk = ~iBusClk;

  canvas_sequencer dut (
    .iBusClk(iBusClk), .iRst(iRst),
    .iPaintReq(iPaintReq), .iPaintX(iPaintX), .iPaintY(iPaintY), .iPaintVal(iPaintVal),
    .oPaintAck(oPaintAck), .iClear(iClear), .iStart(iStart),
    .oRowValid(oRowValid), .oRowIdx(oRowIdx), .oRowData(oRowData), .iRowReady(iRowReady),
    .oFrameDone(oFrameDone), .oAbort(oAbort), .oBusy(oBusy),
    .iDispRow(iDispRow), .oDispData(oDispData), .oInkCount(oInkCount)
  );

  task automatic tick();
    @(posedge iBusClk);
    #1;
  endtask

  task automatic paint(input logic [AW-1:0] x, input logic [AW-1:0] y, input logic v);
    iPaintX = x; iPaintY = y; iPaintVal = v; iPaintReq = 1'b1;
    tick();
    iPaintReq = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iDispRow = 5'd9;
    tick(); tick();
    n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0d want 0", oPaintAck); end
    n_vec++; if (oRowValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d want 0", oRowValid); end
    n_vec++; if (oRowIdx !== 5'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", oRowIdx); end
    n_vec++; if (oFrameDone !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0d want 0", oFrameDone); end
    n_vec++; if (oAbort !== 1'b0) begin n_err++; $display("FAIL reset_abort: got %0d want 0", oAbort); end
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d want 0", oBusy); end
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL reset_ink: got %0d want 0", oInkCount); end
    // Reset must also cancel an in-flight stream and wipe the canvas
    iRst = 1'b0;
    paint(5'd9, 5'd9, 1'b1);
    iStart = 1'b1; tick(); iStart = 1'b0;
    n_vec++; if (oBusy !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy: got %0d want 1", oBusy); end
    iRst = 1'b1; tick(); iRst = 1'b0; #1;
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %0d want 0", oBusy); end
    n_vec++; if (oRowValid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %0d want 0", oRowValid); end
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL reset_mid_ink: got %0d want 0", oInkCount); end
    n_vec++; if (oDispData !== 32'h0) begin n_err++; $display("FAIL reset_mid_row9: got %h want 0", oDispData); end
  endtask

  task automatic test_paint();
    iDispRow = 5'd5;
    iPaintX = 5'd3; iPaintY = 5'd5; iPaintVal = 1'b1; iPaintReq = 1'b1; #1;
    n_vec++; if (oPaintAck !== 1'b1) begin n_err++; $display("FAIL paint_ack: got %0d want 1", oPaintAck); end
    tick(); iPaintReq = 1'b0; #1;
    n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL paint_ack_drop: got %0d want 0", oPaintAck); end
    n_vec++; if (oDispData !== 32'h0000_0008) begin n_err++; $display("FAIL paint_row5: got %h want 00000008", oDispData); end
    n_vec++; if (oInkCount !== 11'd1) begin n_err++; $display("FAIL paint_ink: got %0d want 1", oInkCount); end
    iPaintReq = 1'b1; #1;
    n_vec++; if (oPaintAck !== 1'b1) begin n_err++; $display("FAIL paint_rep_ack: got %0d want 1", oPaintAck); end
    tick(); iPaintReq = 1'b0; #1;
    n_vec++; if (oInkCount !== 11'd1) begin n_err++; $display("FAIL paint_rep_ink: got %0d want 1", oInkCount); end
    iPaintVal = 1'b0; iPaintReq = 1'b1; #1;
    n_vec++; if (oPaintAck !== 1'b1) begin n_err++; $display("FAIL erase_ack: got %0d want 1", oPaintAck); end
    tick(); iPaintReq = 1'b0; #1;
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL erase_ink: got %0d want 0", oInkCount); end
    n_vec++; if (oDispData !== 32'h0) begin n_err++; $display("FAIL erase_row5: got %h want 0", oDispData); end
  endtask

  task automatic test_stream();
    int e;
    int cyc;
    int n;
    logic [COLS-1:0] exp_row;
    paint(5'd0, 5'd0, 1'b1);
    paint(5'd0, 5'd31, 1'b1);
    #1;
    n_vec++; if (oInkCount !== 11'd2) begin n_err++; $display("FAIL stream_ink_pre: got %0d want 2", oInkCount); end
    iStart = 1'b1; tick(); iStart = 1'b0;
    e = 0; cyc = 0;
    while (e < 32 && cyc < 200) begin
      iRowReady = (cyc % 2 == 0); #1;
      exp_row = (e == 0 || e == 31) ? 32'h1 : 32'h0;
      n_vec++; if (oRowValid !== 1'b1) begin n_err++; $display("FAIL stream_valid: got %0d want 1 at row %0d", oRowValid, e); end
      n_vec++; if (oRowIdx !== e[AW-1:0]) begin n_err++; $display("FAIL stream_idx: got %0d want %0d", oRowIdx, e); end
      n_vec++; if (oRowData !== exp_row) begin n_err++; $display("FAIL stream_data: got %h want %h at row %0d", oRowData, exp_row, e); end
      n_vec++; if (oFrameDone !== 1'b0) begin n_err++; $display("FAIL stream_early_done: got %0d want 0", oFrameDone); end
      tick();
      if (iRowReady) e++;
      cyc++;
    end
    iRowReady = 1'b0; #1;
    n_vec++; if (e !== 32) begin n_err++; $display("FAIL stream_rows: got %0d want 32", e); end
    n_vec++; if (oFrameDone !== 1'b1) begin n_err++; $display("FAIL stream_done: got %0d want 1", oFrameDone); end
    n_vec++; if (oRowValid !== 1'b0) begin n_err++; $display("FAIL stream_done_valid: got %0d want 0", oRowValid); end
    tick();
    n_vec++; if (oFrameDone !== 1'b0) begin n_err++; $display("FAIL stream_done_pulse: got %0d want 0", oFrameDone); end
`ifdef AUTO_CLEAR_EN
    n = 0;
    while (oBusy && n < 100) begin n++; tick(); end
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL auto_clear_cycles: got %0d want 32", n); end
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL auto_clear_ink: got %0d want 0", oInkCount); end
`else
    n = 0;
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL stream_idle_busy: got %0d want 0", oBusy); end
    n_vec++; if (oInkCount !== 11'd2) begin n_err++; $display("FAIL stream_ink_kept: got %0d want 2", oInkCount); end
`endif
  endtask

  task automatic test_paint_stall();
    int n;
    iDispRow = 5'd2;
    iPaintX = 5'd5; iPaintY = 5'd2; iPaintVal = 1'b1; iPaintReq = 1'b1; iStart = 1'b1; #1;
    n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL stall_start_ack: got %0d want 0", oPaintAck); end
    tick(); iStart = 1'b0; iRowReady = 1'b1;
    for (int e = 0; e < 32; e++) begin
      #1;
      n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL stall_ack: got %0d want 0 at row %0d", oPaintAck, e); end
      n_vec++; if (oRowIdx !== e[AW-1:0]) begin n_err++; $display("FAIL stall_idx: got %0d want %0d", oRowIdx, e); end
      if (e == 2) begin
        n_vec++; if (oRowData !== 32'h0) begin n_err++; $display("FAIL stall_row2: got %h want 0", oRowData); end
      end
      tick();
    end
    iRowReady = 1'b0; #1;
    n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL stall_done_ack: got %0d want 0", oPaintAck); end
    n_vec++; if (oFrameDone !== 1'b1) begin n_err++; $display("FAIL stall_done: got %0d want 1", oFrameDone); end
    tick();
    n = 0;
    while (oBusy && n < 100) begin
      n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL stall_busy_ack: got %0d want 0", oPaintAck); end
      n++; tick();
    end
    n_vec++; if (oPaintAck !== 1'b1) begin n_err++; $display("FAIL stall_idle_ack: got %0d want 1", oPaintAck); end
    tick(); iPaintReq = 1'b0; #1;
    n_vec++; if (oDispData !== 32'h0000_0020) begin n_err++; $display("FAIL stall_row2_after: got %h want 00000020", oDispData); end
`ifdef AUTO_CLEAR_EN
    n_vec++; if (oInkCount !== 11'd1) begin n_err++; $display("FAIL stall_ink: got %0d want 1", oInkCount); end
`else
    n_vec++; if (oInkCount !== 11'd3) begin n_err++; $display("FAIL stall_ink: got %0d want 3", oInkCount); end
`endif
  endtask

  task automatic test_abort();
    int n;
    int bad;
    int aborts;
    paint(5'd7, 5'd10, 1'b1);
    paint(5'd31, 5'd20, 1'b1);
    iStart = 1'b1; tick(); iStart = 1'b0; iRowReady = 1'b1;
    n = 0;
    while (oRowIdx != 5'd10 && n < 40) begin tick(); n++; end
    iRowReady = 1'b0; iClear = 1'b1; #1;
    n_vec++; if (oRowIdx !== 5'd10) begin n_err++; $display("FAIL abort_at_row: got %0d want 10", oRowIdx); end
    n_vec++; if (oRowData !== 32'h0000_0080) begin n_err++; $display("FAIL abort_row10: got %h want 00000080", oRowData); end
    n_vec++; if (oAbort !== 1'b0) begin n_err++; $display("FAIL abort_early: got %0d want 0", oAbort); end
    tick(); iClear = 1'b0; #1;
    n_vec++; if (oRowValid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %0d want 0", oRowValid); end
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL abort_ink: got %0d want 0", oInkCount); end
    n = 0; bad = 0; aborts = 0;
    while (oBusy && n < 100) begin
      if (oFrameDone || oRowValid) bad++;
      if (oAbort) aborts++;
      n++; tick();
    end
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL abort_clear_cycles: got %0d want 32", n); end
    n_vec++; if (aborts !== 1) begin n_err++; $display("FAIL abort_pulses: got %0d want 1", aborts); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL abort_done_or_valid: got %0d want 0", bad); end
    for (int r = 0; r < 32; r++) begin
      iDispRow = r[AW-1:0]; #1;
      n_vec++; if (oDispData !== 32'h0) begin n_err++; $display("FAIL abort_row_zero: row %0d got %h want 0", r, oDispData); end
    end
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL abort_ink_end: got %0d want 0", oInkCount); end
  endtask

  task automatic test_clear_start();
    int n;
    int seen;
    paint(5'd1, 5'd1, 1'b1); #1;
    n_vec++; if (oInkCount !== 11'd1) begin n_err++; $display("FAIL cs_ink_pre: got %0d want 1", oInkCount); end
    iClear = 1'b1; iStart = 1'b1; iPaintReq = 1'b1; iPaintX = 5'd2; iPaintY = 5'd1; iPaintVal = 1'b1; #1;
    n_vec++; if (oPaintAck !== 1'b0) begin n_err++; $display("FAIL cs_ack: got %0d want 0", oPaintAck); end
    tick(); iClear = 1'b0; iStart = 1'b0; iPaintReq = 1'b0; #1;
    n_vec++; if (oInkCount !== 11'd0) begin n_err++; $display("FAIL cs_ink: got %0d want 0", oInkCount); end
    n = 0; seen = 0;
    while (oBusy && n < 100) begin
      if (oRowValid) seen++;
      n++; tick();
    end
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL cs_clear_cycles: got %0d want 32", n); end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL cs_stream_seen: got %0d want 0", seen); end
    iDispRow = 5'd1; #1;
    n_vec++; if (oDispData !== 32'h0) begin n_err++; $display("FAIL cs_row1: got %h want 0", oDispData); end
  endtask

  task automatic test_back_to_back();
    int n;
    paint(5'd4, 5'd4, 1'b1);
    iRowReady = 1'b1; iStart = 1'b1; tick(); iStart = 1'b0;
    n = 0;
    while (oRowValid && n < 100) begin n++; tick(); end
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL b2b_cycles: got %0d want 32", n); end
    n_vec++; if (oFrameDone !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %0d want 1", oFrameDone); end
    iRowReady = 1'b0;
    tick();
    n = 0;
    while (oBusy && n < 100) begin n++; tick(); end
`ifdef AUTO_CLEAR_EN
    n_vec++; if (n !== 32) begin n_err++; $display("FAIL b2b_auto_clear: got %0d want 32", n); end
`else
    n_vec++; if (n !== 0) begin n_err++; $display("FAIL b2b_idle: got %0d busy cycles want 0", n); end
`endif
  endtask

  initial begin
    test_reset();
    test_paint();
    test_stream();
    test_paint_stall();
    test_abort();
    test_clear_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/canvas_sequencer.md
Name: canvas_sequencer

Overview:
Owns the 32x32 one-bit drawing canvas and schedules every access to it.
- Arbitrates between three requesters: pixel paint/erase from the mouse path, a whole-canvas clear sweep, and row-by-row streaming of the frozen image to the DNN input loader.
- Provides a combinational row-read port for the VGA renderer.
- Keeps a running count of set pixels.

Parameters:
ROWS, 32, canvas rows (Y extent)
COLS, 32, canvas columns (X extent), also the row word width
AW, 5, index width for X and Y (log2 of ROWS and of COLS)
CW, 11, width of the ink counter (must hold ROWS*COLS)

Ports:
iBusClk  in  1  system clock; all state changes on its rising edge
iRst  in  1  synchronous reset, active-high
iPaintReq  in  1  paint request; requester holds it until oPaintAck
iPaintX  in  AW  pixel column
iPaintY  in  AW  pixel row
iPaintVal  in  1  value to write: 1 = ink, 0 = erase
oPaintAck  out  1  one-cycle pulse; the write is committed on this edge
iClear  in  1  clear command, single-cycle pulse
iStart  in  1  start streaming a frame to the DNN, single-cycle pulse
oRowValid  out  1  streamed row is valid
oRowIdx  out  AW  index of the streamed row
oRowData  out  COLS  row contents; bit n = column n
iRowReady  in  1  DNN loader accepts the row
oFrameDone  out  1  one-cycle pulse after the last row is accepted
oAbort  out  1  one-cycle pulse when a stream is cancelled by a clear
oBusy  out  1  high in any state other than IDLE
iDispRow  in  AW  display read row index
oDispData  out  COLS  combinational read of canvas row iDispRow
oInkCount  out  CW  number of set pixels

Behaviour:
Reset (iRst high at the clock edge):
- Canvas cleared to all zeros; FSM goes to IDLE.
- All outputs 0: oPaintAck, oRowValid, oRowIdx, oFrameDone, oAbort, oBusy and oInkCount.
- Reset overrides any operation in progress.

IDLE:
- Priority order: iClear, then iStart, then iPaintReq.
- iClear: go to CLEAR with the row pointer at 0. A simultaneous iStart is dropped; a simultaneous paint is not acked.
- iStart: go to STREAM with the row pointer at 0.
- iPaintReq: write iPaintVal to canvas[iPaintY][iPaintX] and pulse oPaintAck in the same cycle.
  - Ack is given at most once per cycle.
  - A held iPaintReq writes every cycle it is acked; the write is idempotent.

CLEAR:
- Zeroes one row per cycle, row pointer 0 to 31: exactly 32 cycles.
- oInkCount is forced to 0 in the first CLEAR cycle.
- Returns to IDLE after row 31.
- iStart and iClear are ignored; paint requests stall (no ack).

STREAM:
- oRowValid is high; oRowIdx = pointer; oRowData = canvas[pointer].
- Row is transferred when oRowValid and iRowReady are both high; the pointer then increments.
- oRowIdx and oRowData stay stable while iRowReady is low.
- Canvas is frozen: paint requests stall.
- Transfer of row 31 goes to DONE.
- iClear at any point: go to CLEAR, pulse oAbort, drop oRowValid next cycle; oFrameDone is not pulsed.
- iStart is ignored.
- Zero-wait case: with iRowReady tied high, 32 rows take 32 cycles.

DONE:
- One cycle. Pulse oFrameDone, then go to IDLE.

oInkCount:
- Increments on an acked paint that changes a pixel 0 to 1.
- Decrements on an acked paint that changes a pixel 1 to 0.
- Unchanged when the written value equals the current pixel.
- Cannot overflow: maximum value is 1024.

oDispData:
- Purely combinational from the current canvas. The same-cycle write is visible after the edge.

Optional Feature:
AUTO_CLEAR_EN
- Defined: DONE goes to CLEAR instead of IDLE. The canvas is wiped automatically after every completed frame, and oBusy stays high continuously through CLEAR.
- Undefined: DONE goes to IDLE and the canvas is retained until an explicit iClear.

Test Plan:
- Reset, then paint (X=3, Y=5, val 1) -> oPaintAck the same cycle; oDispData for row 5 = 0x00000008; oInkCount = 1; repeating the same paint leaves oInkCount = 1.
- Paint (3,5) with val 0 -> oInkCount = 0; row 5 reads 0.
- Paint rows 0 and 31 with val 1, iStart, iRowReady toggling 1/0 -> 32 transfers with oRowIdx 0..31 in order, data stable during stalls, row 0 = 0x1 and row 31 = 0x1 for column 0, then one oFrameDone pulse and oBusy low.
- iPaintReq held during STREAM -> no ack until IDLE; ack the first IDLE cycle; the canvas streamed to the DNN is unchanged by that paint.
- iClear at row 10 of a stream -> oAbort pulse, no oFrameDone, 32 CLEAR cycles, all rows read 0, oInkCount = 0.
- iClear and iStart in the same IDLE cycle -> CLEAR only, no stream. With AUTO_CLEAR_EN defined, a completed frame is followed immediately by a 32-cycle CLEAR.
